// File: rtl/mult_div_seq.sv
// Multicycle MIPS mult/div sequencer: a shift-add multiplier and a restoring divider, one bit per clock.
// Optional feature macro UNSIGNED_OPS_EN adds op_unsigned for multu/divu.
module mult_div_seq #(
   parameter int WIDTH = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start_mult,
   input  logic             start_div,
`ifdef UNSIGNED_OPS_EN
   input  logic             op_unsigned,
`endif
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   output logic             busy,
   output logic             done,
   output logic             div_zero,
   output logic [WIDTH-1:0] hi_out,
   output logic [WIDTH-1:0] lo_out,
   output logic [2:0]       dbgState
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

   typedef enum logic [2:0] {IDLE, MULT, DIV, FIX, DONE} stateType;

   stateType state, stateNext;

   logic [CW-1:0]      cnt;
   logic [2*WIDTH-1:0] acc;        // mult: {partial, multiplier}; div: lower half is dividend/quotient
   logic [WIDTH-1:0]   remReg;
   logic [WIDTH-1:0]   magA, magB;
   logic               negRes, negRem, isMult;

   logic               opUns;
   logic               signA, signB;
   logic [WIDTH-1:0]   magANext, magBNext;
   logic               startSeen;

`ifdef UNSIGNED_OPS_EN
   assign opUns = op_unsigned;
`else
   assign opUns = 1'b0;
`endif

   assign signA     = op_a[WIDTH-1] & ~opUns;
   assign signB     = op_b[WIDTH-1] & ~opUns;
   assign magANext  = signA ? -op_a : op_a;
   assign magBNext  = signB ? -op_b : op_b;
   assign startSeen = start_mult | start_div;

   // Multiply step: conditional add into the upper half with carry kept for the shift.
   logic [WIDTH:0] mulSum;
   assign mulSum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, magA} : '0);

   // Restoring divide step; the trial remainder needs one extra bit.
   logic [WIDTH:0]   divShift, divDiff;
   logic             qBit;
   logic [WIDTH-1:0] remNext;
   assign divShift = {remReg, acc[WIDTH-1]};
   assign divDiff  = divShift - {1'b0, magB};
   assign qBit     = ~divDiff[WIDTH];
   assign remNext  = qBit ? divDiff[WIDTH-1:0] : divShift[WIDTH-1:0];

   logic [2*WIDTH-1:0] prodFix;
   logic [WIDTH-1:0]   quoFix, remFix;
   assign prodFix = negRes ? -acc : acc;
   assign quoFix  = negRes ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
   assign remFix  = negRem ? -remReg : remReg;

   always_ff @(posedge clock) begin
      if (reset) state <= IDLE;
      else       state <= stateNext;
   end

   always_comb begin
      stateNext = state;
      case (state)
         IDLE: begin
            if (start_mult)     stateNext = MULT;
            else if (start_div) stateNext = (op_b == '0) ? DONE : DIV;
         end
         MULT:    if (cnt == LAST_CNT) stateNext = FIX;
         DIV:     if (cnt == LAST_CNT) stateNext = FIX;
         FIX:     stateNext = DONE;
         DONE:    stateNext = IDLE;
         default: stateNext = IDLE;
      endcase
   end

   always_comb begin
      busy     = (state == MULT) || (state == DIV) || (state == FIX);
      done     = (state == DONE);
      dbgState = state;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         cnt      <= '0;
         acc      <= '0;
         remReg   <= '0;
         magA     <= '0;
         magB     <= '0;
         negRes   <= 1'b0;
         negRem   <= 1'b0;
         isMult   <= 1'b0;
         div_zero <= 1'b0;
         hi_out   <= '0;
         lo_out   <= '0;
      end else begin
         case (state)
            IDLE: if (startSeen) begin
               cnt      <= '0;
               remReg   <= '0;
               magA     <= magANext;
               magB     <= magBNext;
               negRes   <= signA ^ signB;
               negRem   <= signA;
               isMult   <= start_mult;
               div_zero <= ~start_mult & (op_b == '0);
               acc      <= {{WIDTH{1'b0}}, (start_mult ? magBNext : magANext)};
            end
            MULT: begin
               acc <= {mulSum, acc[WIDTH-1:1]};
               cnt <= cnt + 1'b1;
            end
            DIV: begin
               remReg          <= remNext;
               acc[WIDTH-1:0]  <= {acc[WIDTH-2:0], qBit};
               cnt             <= cnt + 1'b1;
            end
            FIX: begin
               hi_out <= isMult ? prodFix[2*WIDTH-1:WIDTH] : remFix;
               lo_out <= isMult ? prodFix[WIDTH-1:0] : quoFix;
            end
            default: ;
         endcase
      end
   end

endmodule
